// File: rtl/vdcm_stream_pkg.sv
// Shared definitions for the VDCM stream transmit path: FSM encoding and
// default geometry of the stream words and the PPS image.
package vdcm_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PPS  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH = 256;
   localparam int unsigned DEF_PPS_WORDS  = 4;

endpackage

// File: rtl/tx_out_reg.sv
// Single-stage valid/ready register slice; the payload is held stable
// while the consumer stalls.
module tx_out_reg #(
   parameter int unsigned WIDTH = 259
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Datapath register is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         data_q <= in_data;
      end
   end

endmodule

// File: rtl/enc_stream_tx.sv
// Frame transmitter: emits the captured PPS words followed by frame_words
// payload words through a single output register stage.
module enc_stream_tx
   import vdcm_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PPS_WORDS  = DEF_PPS_WORDS,
   parameter int unsigned CNT_WIDTH  = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          start,
   input  logic [PPS_WORDS*DATA_WIDTH-1:0] pps,
   input  logic [CNT_WIDTH-1:0]          frame_words,
   input  logic [DATA_WIDTH-1:0]         pl_data,
   input  logic                          pl_valid,
   output logic                          pl_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   output logic                          out_sof,
   output logic                          out_eof,
   output logic                          out_data_is_pps,
   input  logic                          out_ready,
   output logic                          busy
);

   localparam int unsigned    IDX_W    = (PPS_WORDS > 1) ? $clog2(PPS_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPS_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic           ONE_WORD = (PPS_WORDS == 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                        state, state_nxt;
   logic [PPS_WORDS*DATA_WIDTH-1:0] pps_q;
   logic [CNT_WIDTH-1:0]          rem;
   logic [IDX_W-1:0]              idx;
   logic                          busy_q;

   logic                          slot_free;
   logic                          take_start;
   logic                          push;
   logic                          in_valid;
   logic [DATA_WIDTH-1:0]         in_word;
   logic                          in_sof, in_eof, in_pps;
   logic [DATA_WIDTH-1:0]         word_sel;
   logic [DATA_WIDTH+2:0]         reg_q;
   logic                          xfer_eof;

   assign word_sel   = pps_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   assign take_start = (state == ST_IDLE) && start && !busy_q && !flush && slot_free;
   assign push       = in_valid && slot_free;
   assign xfer_eof   = out_valid && out_ready && out_eof;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // PPS word 0 is loaded straight from the pps port on start, so the frame
   // begins on out_valid one cycle after start; the PPS state covers words 1..N-1.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (take_start) begin
               if (!ONE_WORD)                state_nxt = ST_PPS;
               else if (frame_words != '0)   state_nxt = ST_DATA;
            end
         end
         ST_PPS: begin
            if (push && idx == LAST_IDX) begin
               state_nxt = (rem != '0) ? ST_DATA : ST_IDLE;
            end
         end
         ST_DATA: begin
            if (push && rem == CNT_ONE) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_valid = 1'b0;
      in_word  = word_sel;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
      in_pps   = 1'b0;
      pl_ready = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_valid = take_start;
            in_word  = pps[DATA_WIDTH-1:0];
            in_sof   = 1'b1;
            in_eof   = ONE_WORD && (frame_words == '0);
            in_pps   = 1'b1;
         end
         ST_PPS: begin
            in_valid = 1'b1;
            in_eof   = (idx == LAST_IDX) && (rem == '0);
            in_pps   = 1'b1;
         end
         ST_DATA: begin
            in_valid = pl_valid && (rem != '0);
            in_word  = pl_data;
            in_eof   = (rem == CNT_ONE);
            pl_ready = slot_free && (rem != '0);
         end
         default: ;
      endcase
   end

   // busy stays high until the eof word actually leaves the output register.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rem    <= '0;
         idx    <= '0;
         busy_q <= 1'b0;
      end else begin
         if (take_start) begin
            rem    <= frame_words;
            idx    <= IDX_ONE;
            busy_q <= 1'b1;
         end else if (xfer_eof) begin
            busy_q <= 1'b0;
         end
         if (push && state == ST_PPS) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
         end
         if (push && state == ST_DATA) begin
            rem <= rem - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (take_start) begin
         pps_q <= pps;
      end
   end

   tx_out_reg #(
      .WIDTH(DATA_WIDTH + 3)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .in_valid  (in_valid),
      .in_ready  (slot_free),
      .in_data   ({in_sof, in_eof, in_pps, in_word}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (reg_q)
   );

   assign out_data        = reg_q[DATA_WIDTH-1:0];
   assign out_sof         = out_valid && reg_q[DATA_WIDTH+2];
   assign out_eof         = out_valid && reg_q[DATA_WIDTH+1];
   assign out_data_is_pps = out_valid && reg_q[DATA_WIDTH];
   assign busy            = busy_q;

endmodule

// File: tb/tb_enc_stream_tx.sv
// Directed bench for enc_stream_tx with a narrow configuration so that the
// full-scale payload count is reachable.
module tb_enc_stream_tx;

   localparam int W    = 16;
   localparam int PW   = 4;
   localparam int CW   = 4;
   localparam logic [PW*W-1:0] PPS_IMG = 64'h0A03_0A02_0A01_0A00;

   logic          clk = 1'b0;
   logic          rst, flush, start, pl_valid, pl_ready, out_ready;
   logic [PW*W-1:0] pps;
   logic [CW-1:0] frame_words;
   logic [W-1:0]  pl_data, out_data;
   logic          out_valid, out_sof, out_eof, out_data_is_pps, busy;

   enc_stream_tx #(
      .DATA_WIDTH(W),
      .PPS_WORDS (PW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start), .pps(pps),
      .frame_words(frame_words), .pl_data(pl_data), .pl_valid(pl_valid),
      .pl_ready(pl_ready), .out_data(out_data), .out_valid(out_valid),
      .out_sof(out_sof), .out_eof(out_eof), .out_data_is_pps(out_data_is_pps),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int sent;
   int prready_cnt;
   bit mon_en = 1'b0;
   logic [W+2:0] rxq[$];
   logic [W+2:0] cur;
   logic         hold_q = 1'b0;
   logic [W+2:0] hold_w;

   assign cur = {out_sof, out_eof, out_data_is_pps, out_data};

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Transfers complete at the next posedge; inputs are stable from posedge+1.
   always @(negedge clk) begin
      if (mon_en) begin
         if (hold_q) check("stall_stable", {out_valid, cur}, {1'b1, hold_w});
         if (!out_valid) check("idle_flags", {out_sof, out_eof, out_data_is_pps}, 3'b000);
         if (out_valid && out_ready) rxq.push_back(cur);
         hold_q = out_valid && !out_ready;
         hold_w = cur;
      end
   end

   task automatic cycle(input bit st, input bit fl, input bit ordy, input bit pv);
      start     = st;
      flush     = fl;
      out_ready = ordy;
      pl_valid  = pv;
      pl_data   = 16'hD000 + sent[15:0];
      @(negedge clk);
      if (pl_valid && pl_ready) sent++;
      if (pl_ready) prready_cnt++;
      @(posedge clk);
      #1;
   endtask

   // mode 0: free-running, 1: out_ready toggling with pl_valid gaps, 2: start held while busy
   task automatic run_frame(input logic [CW-1:0] fw, input int mode);
      int  n;
      bit  tog;
      sent = 0;
      prready_cnt = 0;
      rxq.delete();
      pps = PPS_IMG;
      frame_words = fw;
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      pps = ~PPS_IMG;
      frame_words = ~fw;
      n = 0;
      tog = 1'b1;
      while (busy && n < 200) begin
         case (mode)
            1: begin
               cycle(1'b0, 1'b0, tog, ($urandom_range(0, 2) != 0));
               tog = !tog;
            end
            2: cycle(1'b1, 1'b0, 1'b1, 1'b1);
            default: cycle(1'b0, 1'b0, 1'b1, 1'b1);
         endcase
         n++;
      end
      check("frame_done_busy", busy, 1'b0);
      repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check("trailing_idle_valid", out_valid, 1'b0);
   endtask

   task automatic check_frame(input string nm, input int fw);
      int nexp;
      logic [W+2:0] e;
      nexp = PW + fw;
      check({nm, "_count"}, rxq.size(), nexp);
      for (int i = 0; i < nexp && i < rxq.size(); i++) begin
         if (i < PW) e = {(i == 0), (fw == 0 && i == PW - 1), 1'b1, 16'h0A00 + 16'(i)};
         else        e = {1'b0, (i == nexp - 1), 1'b0, 16'hD000 + 16'(i - PW)};
         check({nm, "_word"}, rxq[i], e);
      end
   endtask

   typedef struct {
      bit          st;
      bit          pv;
      logic [W-1:0] pd;
      bit          ordy;
      bit          ev;
      logic [W-1:0] ed;
      bit          es, ee, ep, eb, epr;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      // frame_words=3, continuous flow: 7 contiguous words from the cycle after start
      tbl[0] = '{1, 1, 16'hBEEF, 1, 0, 16'h0000, 0, 0, 0, 0, 0};
      tbl[1] = '{0, 1, 16'hBEEF, 1, 1, 16'h0A00, 1, 0, 1, 1, 0};
      tbl[2] = '{0, 1, 16'hBEEF, 1, 1, 16'h0A01, 0, 0, 1, 1, 0};
      tbl[3] = '{0, 1, 16'hBEEF, 1, 1, 16'h0A02, 0, 0, 1, 1, 0};
      tbl[4] = '{0, 1, 16'hD000, 1, 1, 16'h0A03, 0, 0, 1, 1, 1};
      tbl[5] = '{0, 1, 16'hD001, 1, 1, 16'hD000, 0, 0, 0, 1, 1};
      tbl[6] = '{0, 1, 16'hD002, 1, 1, 16'hD001, 0, 0, 0, 1, 1};
      tbl[7] = '{0, 1, 16'hBEEF, 1, 1, 16'hD002, 0, 1, 0, 1, 0};
      tbl[8] = '{0, 1, 16'hBEEF, 1, 0, 16'h0000, 0, 0, 0, 0, 0};

      rst = 1'b1; flush = 1'b0; start = 1'b0; pl_valid = 1'b0; out_ready = 1'b1;
      pl_data = '0; pps = PPS_IMG; frame_words = '0; sent = 0; prready_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {out_valid, out_sof, out_eof, out_data_is_pps, busy, pl_ready}, 6'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ctrl", {out_valid, busy, pl_ready}, 3'b0);
      mon_en = 1'b1;

      rxq.delete();
      frame_words = 4'd3;
      for (int i = 0; i < 9; i++) begin
         start = tbl[i].st; pl_valid = tbl[i].pv; pl_data = tbl[i].pd; out_ready = tbl[i].ordy;
         #1;
         check("tbl_valid", out_valid, tbl[i].ev);
         if (tbl[i].ev) check("tbl_data", out_data, tbl[i].ed);
         check("tbl_flags", {out_sof, out_eof, out_data_is_pps}, {tbl[i].es, tbl[i].ee, tbl[i].ep});
         check("tbl_busy", busy, tbl[i].eb);
         check("tbl_pl_ready", pl_ready, tbl[i].epr);
         @(posedge clk);
         #1;
      end
      check_frame("tbl_frame", 3);

      run_frame(4'd0, 0);
      check_frame("fw0", 0);
      check("fw0_pl_ready_never", prready_cnt, 0);

      run_frame(4'd5, 1);
      check_frame("stall5", 5);

      run_frame(4'd15, 0);
      check_frame("fwmax", 15);

      // flush while payload word 1 is on the output
      sent = 0; rxq.delete(); pps = PPS_IMG; frame_words = 4'd10;
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      n = 0;
      while (!(out_valid && !out_data_is_pps && out_data == 16'hD001) && n < 50) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b1);
         n++;
      end
      check("flush_reach_word", n < 50, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      check("flush_next", {out_valid, busy, pl_ready}, 3'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check("flush_stays_idle", {out_valid, busy}, 2'b0);
      run_frame(4'd2, 0);
      check_frame("after_flush", 2);

      run_frame(4'd2, 2);
      check_frame("start_while_busy", 2);

      // reset in the middle of the PPS words
      sent = 0; rxq.delete(); pps = PPS_IMG; frame_words = 4'd3;
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check("pre_rst_in_pps", {out_valid, out_data_is_pps, busy}, 3'b111);
      rst = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      check("midrst_ctrl", {out_valid, out_sof, out_eof, out_data_is_pps, busy, pl_ready}, 6'b0);
      run_frame(4'd1, 0);
      check_frame("after_rst", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
